// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C target with a byte-wide register file, pointer
// auto-increment, burst read/write, repeated START and glitch-filtered pads.
// Register 0 is read-only and returns parallel_in when read.
module i2c_reg_target #(
   parameter int         REG_COUNT     = 20,
   parameter int         ADDR_SEL_BITS = 2,
   parameter logic [6:0] BASE_ADDR     = 7'h48,
   parameter int         FILTER_LEN    = 3,
   localparam int        PTR_W         = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1,
   localparam int        SEL_W         = (ADDR_SEL_BITS > 0) ? ADDR_SEL_BITS : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   scl_in,
   input  logic                   sda_in,
   output logic                   sda_oe,
   input  logic [SEL_W-1:0]       addr_sel,
   input  logic [7:0]             parallel_in,
   output logic [8*REG_COUNT-1:0] registers_packed,
   output logic                   wr_strobe,
   output logic [PTR_W-1:0]       wr_index,
   output logic                   busy
);

   localparam int         CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [6:0] SEL_MASK = 7'((1 << ADDR_SEL_BITS) - 1);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
   } state_t;

   // bit 0 carries SCL, bit 1 carries SDA through the conditioning path
   logic [1:0] syncA_q, syncB_q, filt_q, filt_d, filtPrev_q;

   state_t         state_q, state_d;
   logic [3:0]     bitCnt_q, bitCnt_d;
   logic [6:0]     rxShift_q, rxShift_d;
   logic [6:0]     txShift_q, txShift_d;
   logic [PTR_W-1:0] ptr_q, ptr_d, ptrNext;
   logic           sdaOe_q, sdaOe_d;
   logic           busy_q, busy_d;
   logic           rw_q, rw_d;
   logic           wrStrobe_q, wrStrobe_d;
   logic [PTR_W-1:0] wrIndex_q, wrIndex_d;
   logic           regWe;
   logic [7:0]     rxByte, loadByte;
   logic [6:0]     targetAddr;
   logic [7:0]     regs_q [REG_COUNT];

   logic sclF, sdaF, sclRise, sclFall, startCond, stopCond;

   // Two-flop synchronisers plus the filtered value and its one-clock history for edge detection.
   // Reset to the idle-bus level so leaving reset never fakes an edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         syncA_q    <= 2'b11;
         syncB_q    <= 2'b11;
         filt_q     <= 2'b11;
         filtPrev_q <= 2'b11;
      end else begin
         syncA_q    <= {sda_in, scl_in};
         syncB_q    <= syncA_q;
         filt_q     <= filt_d;
         filtPrev_q <= filt_q;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : gFilt
      logic [CNT_W-1:0] cnt_q;

      // Count consecutive samples that disagree with the filtered value; any agreeing sample restarts the count.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            cnt_q <= '0;
         end else if (syncB_q[g] == filt_q[g] || cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign filt_d[g] = (syncB_q[g] != filt_q[g] && cnt_q == CNT_W'(FILTER_LEN - 1))
                         ? syncB_q[g] : filt_q[g];
   end

   assign sclF      = filt_q[0];
   assign sdaF      = filt_q[1];
   assign sclRise   = filt_q[0] & ~filtPrev_q[0];
   assign sclFall   = ~filt_q[0] & filtPrev_q[0];
   assign startCond = filtPrev_q[1] & ~sdaF & sclF & filtPrev_q[0];
   assign stopCond  = ~filtPrev_q[1] & sdaF & sclF & filtPrev_q[0];

   assign targetAddr = (BASE_ADDR & ~SEL_MASK) | (7'(addr_sel) & SEL_MASK);

   // State register and all per-transaction bookkeeping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         bitCnt_q   <= '0;
         rxShift_q  <= '0;
         txShift_q  <= '0;
         ptr_q      <= '0;
         sdaOe_q    <= 1'b0;
         busy_q     <= 1'b0;
         rw_q       <= 1'b0;
         wrStrobe_q <= 1'b0;
         wrIndex_q  <= '0;
      end else begin
         state_q    <= state_d;
         bitCnt_q   <= bitCnt_d;
         rxShift_q  <= rxShift_d;
         txShift_q  <= txShift_d;
         ptr_q      <= ptr_d;
         sdaOe_q    <= sdaOe_d;
         busy_q     <= busy_d;
         rw_q       <= rw_d;
         wrStrobe_q <= wrStrobe_d;
         wrIndex_q  <= wrIndex_d;
      end
   end

   // Register file; register 0 is never written so it stays at its reset value.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      end else if (regWe) begin
         regs_q[ptr_q] <= rxByte;
      end
   end

   // Next-state logic: STOP beats START beats per-state bit handling.
   // Byte-level decisions happen on the 8th SCL rise; ACK slots are bounded by
   // the falls either side of the 9th rise (bitCnt 8 then 9).
   always_comb begin
      state_d    = state_q;
      bitCnt_d   = bitCnt_q;
      rxShift_d  = rxShift_q;
      txShift_d  = txShift_q;
      ptr_d      = ptr_q;
      sdaOe_d    = sdaOe_q;
      busy_d     = busy_q;
      rw_d       = rw_q;
      wrStrobe_d = 1'b0;
      wrIndex_d  = wrIndex_q;
      regWe      = 1'b0;
      rxByte     = {rxShift_q, sdaF};
      loadByte   = (ptr_q == '0) ? parallel_in : regs_q[ptr_q];
      ptrNext    = (ptr_q == PTR_W'(REG_COUNT - 1)) ? '0 : ptr_q + 1'b1;

      if (stopCond) begin
         state_d  = IDLE;
         sdaOe_d  = 1'b0;
         busy_d   = 1'b0;
         bitCnt_d = '0;
      end else if (startCond) begin
         state_d  = ADDR;
         sdaOe_d  = 1'b0;
         bitCnt_d = '0;
      end else begin
         case (state_q)
            ADDR, PTR, WDATA: begin
               if (sclRise) begin
                  rxShift_d = rxByte[6:0];
                  bitCnt_d  = bitCnt_q + 4'd1;
                  if (bitCnt_q == 4'd7) begin
                     if (state_q == ADDR) begin
                        if (rxByte[7:1] == targetAddr) begin
                           state_d = ADDR_ACK;
                           busy_d  = 1'b1;
                           rw_d    = rxByte[0];
                        end else begin
                           state_d  = IDLE;
                           busy_d   = 1'b0;
                           bitCnt_d = '0;
                        end
                     end else if (state_q == PTR) begin
                        if (int'(rxByte) < REG_COUNT) begin
                           ptr_d   = rxByte[PTR_W-1:0];
                           state_d = PTR_ACK;
                        end else begin
                           state_d  = IDLE;
                           busy_d   = 1'b0;
                           bitCnt_d = '0;
                        end
                     end else begin
                        if (ptr_q != '0) begin
                           regWe      = 1'b1;
                           wrStrobe_d = 1'b1;
                           wrIndex_d  = ptr_q;
                        end
                        ptr_d   = ptrNext;
                        state_d = WDATA_ACK;
                     end
                  end
               end
            end
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (sclFall) begin
                  if (bitCnt_q == 4'd8) begin
                     sdaOe_d  = 1'b1;
                     bitCnt_d = 4'd9;
                  end else begin
                     sdaOe_d  = 1'b0;
                     bitCnt_d = '0;
                     if (state_q == ADDR_ACK && rw_q) begin
                        state_d   = RDATA;
                        txShift_d = loadByte[6:0];
                        sdaOe_d   = ~loadByte[7];
                     end else if (state_q == ADDR_ACK) begin
                        state_d = PTR;
                     end else begin
                        state_d = WDATA;
                     end
                  end
               end
            end
            RDATA: begin
               if (sclRise) begin
                  bitCnt_d = bitCnt_q + 4'd1;
               end else if (sclFall && bitCnt_q != '0) begin
                  if (bitCnt_q == 4'd8) begin
                     sdaOe_d = 1'b0;
                     state_d = RDATA_ACK;
                  end else begin
                     sdaOe_d   = ~txShift_q[6];
                     txShift_d = {txShift_q[5:0], 1'b0};
                  end
               end
            end
            RDATA_ACK: begin
               if (sclRise && bitCnt_q == 4'd8) begin
                  ptr_d = ptrNext;
                  if (sdaF) begin
                     state_d  = IDLE;
                     busy_d   = 1'b0;
                     bitCnt_d = '0;
                  end else begin
                     bitCnt_d = 4'd9;
                  end
               end else if (sclFall && bitCnt_q == 4'd9) begin
                  txShift_d = loadByte[6:0];
                  sdaOe_d   = ~loadByte[7];
                  bitCnt_d  = '0;
                  state_d   = RDATA;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   for (genvar i = 0; i < REG_COUNT; i++) begin : gPack
      assign registers_packed[8*i +: 8] = regs_q[i];
   end

   assign sda_oe    = sdaOe_q;
   assign busy      = busy_q;
   assign wr_strobe = wrStrobe_q;
   assign wr_index  = wrIndex_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target: drives an I2C controller model against i2c_reg_target
// and compares against a behavioural register-file/pointer model.
module tb_i2c_reg_target;

   localparam int         REG_COUNT = 20;
   localparam int         Q         = 10;
   localparam logic [6:0] TARGET    = 7'h49;

   logic                   clock = 1'b0;
   logic                   reset = 1'b0;
   logic                   sclDrv = 1'b1;
   logic                   sdaDrv = 1'b1;
   logic                   sdaBus;
   logic                   sda_oe;
   logic [1:0]             addr_sel = 2'b01;
   logic [7:0]             parallel_in = 8'hC3;
   logic [8*REG_COUNT-1:0] registers_packed;
   logic                   wr_strobe;
   logic [4:0]             wr_index;
   logic                   busy;

   int errors = 0;
   int checks = 0;

   logic [7:0] mReg [REG_COUNT];
   int         mPtr = 0;
   int         expStrobe[$];
   int         strobeLog[$];
   int         strobeRd = 0;
   int         oeCount = 0;
   logic [7:0] rdLog[$];
   logic [7:0] wrBuf [8];
   bit         glitch = 1'b0;

   assign sdaBus = sdaDrv & ~sda_oe;

   i2c_reg_target dut (
      .clock(clock),
      .reset(reset),
      .scl_in(sclDrv),
      .sda_in(sdaBus),
      .sda_oe(sda_oe),
      .addr_sel(addr_sel),
      .parallel_in(parallel_in),
      .registers_packed(registers_packed),
      .wr_strobe(wr_strobe),
      .wr_index(wr_index),
      .busy(busy)
   );

   always #5 clock = ~clock;

   // Log write strobes and SDA pull-down cycles away from the active edge.
   always @(negedge clock) begin
      if (wr_strobe) strobeLog.push_back(int'(wr_index));
      if (sda_oe) oeCount++;
   end

   task automatic waitClk(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8*REG_COUNT-1:0] modelPacked();
      logic [8*REG_COUNT-1:0] r;
      for (int i = 0; i < REG_COUNT; i++) r[8*i +: 8] = mReg[i];
      return r;
   endfunction

   task automatic checkStrobes();
      int got;
      got = strobeLog.size() - strobeRd;
      checkOutput("strobe_count", got, expStrobe.size());
      for (int i = 0; i < expStrobe.size() && i < got; i++)
         checkOutput("strobe_index", strobeLog[strobeRd + i], expStrobe[i]);
      strobeRd = strobeLog.size();
      expStrobe.delete();
   endtask

   task automatic i2cStart();
      sdaDrv = 1'b1; waitClk(Q);
      sclDrv = 1'b1; waitClk(Q);
      sdaDrv = 1'b0; waitClk(Q);
      sclDrv = 1'b0; waitClk(2);
   endtask

   task automatic i2cStop();
      sdaDrv = 1'b0; waitClk(Q);
      sclDrv = 1'b1; waitClk(Q);
      sdaDrv = 1'b1; waitClk(Q);
   endtask

   // Send one byte MSB first; ack reports whether the target pulled SDA in the 9th bit.
   task automatic applyStimulus(input logic [7:0] b, output bit ack);
      for (int i = 7; i >= 0; i--) begin
         sdaDrv = b[i]; waitClk(Q);
         sclDrv = 1'b1; waitClk(Q);
         if (glitch && i == 4) begin
            sclDrv = 1'b0; waitClk(2);
            sclDrv = 1'b1;
         end
         waitClk(Q);
         sclDrv = 1'b0; waitClk(2);
      end
      sdaDrv = 1'b1; waitClk(Q);
      sclDrv = 1'b1; waitClk(Q);
      ack = sda_oe;
      waitClk(Q);
      sclDrv = 1'b0; waitClk(2);
   endtask

   task automatic readByte(input bit nack, output logic [7:0] b);
      sdaDrv = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         waitClk(Q);
         sclDrv = 1'b1; waitClk(Q);
         b[i] = sdaBus;
         waitClk(Q);
         sclDrv = 1'b0; waitClk(2);
      end
      sdaDrv = nack; waitClk(Q);
      sclDrv = 1'b1; waitClk(2*Q);
      sclDrv = 1'b0; waitClk(2);
      sdaDrv = 1'b1;
   endtask

   task automatic writeTxn(input logic [7:0] addrByte, input logic [7:0] p, input int n);
      bit ack;
      bit addrOk;
      bit ptrOk;
      addrOk = (addrByte[7:1] == TARGET) && !addrByte[0];
      ptrOk  = (p < REG_COUNT);
      i2cStart();
      applyStimulus(addrByte, ack);
      checkOutput("addr_ack", ack, addrOk);
      checkOutput("busy_after_addr", busy, addrOk);
      if (addrOk) begin
         applyStimulus(p, ack);
         checkOutput("ptr_ack", ack, ptrOk);
         if (ptrOk) begin
            mPtr = p;
            for (int i = 0; i < n; i++) begin
               applyStimulus(wrBuf[i], ack);
               checkOutput("data_ack", ack, 1'b1);
               if (mPtr != 0) begin
                  mReg[mPtr] = wrBuf[i];
                  expStrobe.push_back(mPtr);
               end
               mPtr = (mPtr + 1) % REG_COUNT;
            end
         end
      end
      i2cStop();
      checkOutput("busy_after_stop", busy, 1'b0);
      checkOutput("regs", registers_packed, modelPacked());
      checkStrobes();
   endtask

   task automatic readTxn(input bit setPtr, input logic [7:0] p, input int n);
      bit ack;
      logic [7:0] b;
      logic [7:0] e;
      i2cStart();
      if (setPtr) begin
         applyStimulus(8'h92, ack);
         checkOutput("rd_waddr_ack", ack, 1'b1);
         applyStimulus(p, ack);
         checkOutput("rd_ptr_ack", ack, p < REG_COUNT);
         if (!(p < REG_COUNT)) begin
            i2cStop();
            return;
         end
         mPtr = p;
         i2cStart();
      end
      applyStimulus(8'h93, ack);
      checkOutput("rd_addr_ack", ack, 1'b1);
      for (int i = 0; i < n; i++) begin
         readByte(i == n - 1, b);
         e = (mPtr == 0) ? parallel_in : mReg[mPtr];
         mPtr = (mPtr + 1) % REG_COUNT;
         checkOutput("rd_data", b, e);
         rdLog.push_back(b);
      end
      i2cStop();
      checkOutput("rd_busy_after_stop", busy, 1'b0);
   endtask

   initial begin : main
      bit found;
      int oeBefore;
      int n;
      logic [7:0] p;

      for (int i = 0; i < REG_COUNT; i++) mReg[i] = 8'h00;

      $display("[TB] reset state");
      waitClk(3);
      checkOutput("rst_sda_oe", sda_oe, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_wr_strobe", wr_strobe, 1'b0);
      checkOutput("rst_wr_index", wr_index, 5'd0);
      checkOutput("rst_regs", registers_packed, '0);
      reset = 1'b1;
      waitClk(3);

      $display("[TB] preload registers 1..2");
      wrBuf[0] = 8'h31; wrBuf[1] = 8'h32;
      writeTxn(8'h92, 8'd1, 2);

      $display("[TB] burst write");
      wrBuf[0] = 8'hA5; wrBuf[1] = 8'h5A;
      writeTxn(8'h92, 8'd3, 2);
      checkOutput("reg3", registers_packed[31:24], 8'hA5);
      checkOutput("reg4", registers_packed[39:32], 8'h5A);

      $display("[TB] wrap and read-only register 0");
      wrBuf[0] = 8'h11; wrBuf[1] = 8'h22;
      writeTxn(8'h92, 8'd19, 2);
      checkOutput("reg19", registers_packed[159:152], 8'h11);
      checkOutput("reg0", registers_packed[7:0], 8'h00);

      $display("[TB] current-address read after wrap");
      rdLog.delete();
      readTxn(1'b0, 8'd0, 2);
      checkOutput("cur_rd0", rdLog[0], 8'h31);

      $display("[TB] repeated-START burst read");
      rdLog.delete();
      readTxn(1'b1, 8'd19, 2);
      checkOutput("burst_rd0", rdLog[0], 8'h11);
      checkOutput("burst_rd1", rdLog[1], 8'hC3);
      rdLog.delete();
      readTxn(1'b0, 8'd0, 1);
      checkOutput("ptr_after_read", rdLog[0], 8'h31);

      $display("[TB] address mismatch");
      oeBefore = oeCount;
      wrBuf[0] = 8'hEE;
      writeTxn(8'h90, 8'd5, 1);
      checkOutput("mismatch_oe_cycles", oeCount - oeBefore, 0);

      $display("[TB] out-of-range pointer");
      wrBuf[0] = 8'h77;
      writeTxn(8'h92, 8'd20, 1);

      $display("[TB] SCL glitch rejection");
      glitch = 1'b1;
      wrBuf[0] = 8'h6C; wrBuf[1] = 8'h93;
      writeTxn(8'h92, 8'd7, 2);
      glitch = 1'b0;
      checkOutput("glitch_reg7", registers_packed[63:56], 8'h6C);

      $display("[TB] reset during read");
      begin
         bit ack;
         i2cStart();
         applyStimulus(8'h92, ack);
         applyStimulus(8'd4, ack);
         i2cStart();
         applyStimulus(8'h93, ack);
         found = 1'b0;
         for (int i = 0; i < 40 && !found; i++) begin
            if (sda_oe) found = 1'b1;
            else waitClk(1);
         end
         checkOutput("mid_read_oe_seen", found, 1'b1);
         reset = 1'b0;
         #2;
         checkOutput("async_rst_oe", sda_oe, 1'b0);
         checkOutput("async_rst_regs", registers_packed, '0);
         sclDrv = 1'b1;
         sdaDrv = 1'b1;
         waitClk(3);
         reset = 1'b1;
         waitClk(3);
         checkOutput("post_rst_busy", busy, 1'b0);
         checkOutput("post_rst_oe", sda_oe, 1'b0);
         for (int i = 0; i < REG_COUNT; i++) mReg[i] = 8'h00;
         mPtr = 0;
         strobeRd = strobeLog.size();
         parallel_in = 8'($urandom);
         readTxn(1'b0, 8'd0, 1);
      end

      $display("[TB] randomized transactions");
      for (int t = 0; t < 8; t++) begin
         p = 8'($urandom_range(0, 23));
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) wrBuf[i] = 8'($urandom);
         parallel_in = 8'($urandom);
         if ($urandom_range(0, 1) == 0) writeTxn(8'h92, p, n);
         else readTxn(1'b1, p, n);
      end
      checkOutput("final_regs", registers_packed, modelPacked());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
